// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Instruction memory with combinational fetch port and a
//               byte-stream program loader. Bytes are packed big-endian into
//               32-bit words and written from word 0 upward. While a load is
//               running the core is held and the fetch port returns zero.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
    parameter int N_INST_ADDR = 32,
    parameter int N_INST_DATA = 32,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_inst_ren,
    input  logic [N_INST_ADDR-1:0] i_inst_addr,
    output logic [N_INST_DATA-1:0] o_inst_data,
    input  logic                   i_ld_start,
    input  logic [DEPTH_LOG2:0]    i_ld_len,
    input  logic                   i_ld_byte_vld,
    input  logic [7:0]             i_ld_byte,
    output logic                   o_ld_byte_rdy,
    output logic                   o_ld_busy,
    output logic                   o_core_hold,
    output logic                   o_ld_done,
    output logic                   o_ld_err,
    output logic [31:0]            o_ld_sum
);

    localparam int                  C_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_MAX_LEN = C_DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [DEPTH_LOG2:0]    r_len;
    logic [DEPTH_LOG2:0]    r_word_cnt;
    logic [1:0]             r_byte_cnt;
    logic [N_INST_DATA-1:0] r_word_buf;
    logic [31:0]            r_sum;
    logic                   r_err;
    logic                   r_busy;
    logic                   r_rdy;
    logic                   r_done;

    logic [N_INST_DATA-1:0] r_mem [0:C_DEPTH-1];

    logic [DEPTH_LOG2:0]    w_word_cnt_nxt;
    logic [DEPTH_LOG2-1:0]  w_word_idx;
    logic                   w_oor;
    logic                   w_unused_addr_lo;

    assign w_word_cnt_nxt   = r_word_cnt + C_CNT_ONE;
    assign w_word_idx       = i_inst_addr[DEPTH_LOG2+1:2];
    // Byte offset within a word is irrelevant for word-aligned fetches.
    assign w_unused_addr_lo = ^i_inst_addr[1:0];

    // Any address bit above the memory window marks the fetch out of range.
    generate
        if (N_INST_ADDR > DEPTH_LOG2 + 2) begin : g_oor_chk
            assign w_oor = |i_inst_addr[N_INST_ADDR-1:DEPTH_LOG2+2];
        end else begin : g_oor_none
            assign w_oor = 1'b0;
        end
    endgenerate

    // Fetch is combinational; held core and invalid fetches see zero.
    assign o_inst_data = (i_inst_ren && !r_busy && !w_oor) ? r_mem[w_word_idx] : '0;

    assign o_ld_byte_rdy = r_rdy;
    assign o_ld_busy     = r_busy;
    assign o_core_hold   = r_busy;
    assign o_ld_done     = r_done;
    assign o_ld_err      = r_err;
    assign o_ld_sum      = r_sum;

    // Memory array has no reset so words survive a reset mid-load.
    always_ff @(posedge i_clk) begin
        if (r_state == S_WRITE) begin
            r_mem[r_word_cnt[DEPTH_LOG2-1:0]] <= r_word_buf;
        end
    end

    // Loader FSM with registered status outputs updated on each transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= 2'd0;
            r_word_buf <= '0;
            r_sum      <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_rdy      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ld_start) begin
                        r_len      <= i_ld_len;
                        r_word_cnt <= '0;
                        r_byte_cnt <= 2'd0;
                        r_sum      <= '0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (i_ld_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (i_ld_len > C_MAX_LEN) begin
                            // Program does not fit: flag it and write nothing.
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_rdy   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_ld_byte_vld) begin
                        case (r_byte_cnt)
                            2'd0:    r_word_buf[31:24] <= i_ld_byte;
                            2'd1:    r_word_buf[23:16] <= i_ld_byte;
                            2'd2:    r_word_buf[15:8]  <= i_ld_byte;
                            default: r_word_buf[7:0]   <= i_ld_byte;
                        endcase
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= S_WRITE;
                            r_rdy   <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    r_sum      <= r_sum + r_word_buf;
                    r_word_cnt <= w_word_cnt_nxt;
                    if (w_word_cnt_nxt == r_len) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                        r_rdy   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_loader
// Description : Self-checking bench for inst_mem_loader. Packed words are
//               pushed to a scoreboard as bytes are streamed and popped when
//               fetched back after the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        ld_start;
    logic [DL:0] ld_len;
    logic        ld_byte_vld;
    logic [7:0]  ld_byte;
    logic        ld_byte_rdy;
    logic        ld_busy;
    logic        core_hold;
    logic        ld_done;
    logic        ld_err;
    logic [31:0] ld_sum;

    always #5 clk = ~clk;

    inst_mem_loader #(.N_INST_ADDR(32), .N_INST_DATA(32), .DEPTH_LOG2(DL)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_inst_ren   (inst_ren),
        .i_inst_addr  (inst_addr),
        .o_inst_data  (inst_data),
        .i_ld_start   (ld_start),
        .i_ld_len     (ld_len),
        .i_ld_byte_vld(ld_byte_vld),
        .i_ld_byte    (ld_byte),
        .o_ld_byte_rdy(ld_byte_rdy),
        .o_ld_busy    (ld_busy),
        .o_core_hold  (core_hold),
        .o_ld_done    (ld_done),
        .o_ld_err     (ld_err),
        .o_ld_sum     (ld_sum)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    logic [7:0]  bytes_q[$];

    // Observations recorded by the load driver for the test tasks to judge.
    int          n_acc, n_done, hold_bad, rdy_bad;
    logic        err_at_done, hold_after;
    bit          timed_out;
    logic [31:0] sum_exp;

    // Streams bytes_q into the loader; mid_cyc pulses a stray start, stop_after
    // ends streaming after that many accepted bytes (0 = run to completion).
    task automatic drive_load(input int len, input int gap, input int mid_cyc, input int stop_after);
        int          idx = 0;
        int          gap_left = 0;
        int          cyc = 0;
        int          word_idx = 0;
        logic [31:0] acc_word = '0;
        bit          done_seen = 0;
        bit          write_next = 0;
        bit          acc;
        bit          stop = 0;
        n_acc = 0; n_done = 0; hold_bad = 0; rdy_bad = 0;
        err_at_done = 1'b0; hold_after = 1'bx; timed_out = 0; sum_exp = '0;
        inst_ren    = 1'b1;
        inst_addr   = 32'h0;
        ld_len      = (DL+1)'(len);
        ld_start    = 1'b1;
        ld_byte_vld = (bytes_q.size() > 0);
        ld_byte     = (bytes_q.size() > 0) ? bytes_q[0] : 8'h00;
        @(posedge clk); #1;
        ld_start = 1'b0;
        ld_len   = (DL+1)'(3);
        while (!stop) begin
            @(negedge clk);
            if (done_seen) begin
                hold_after = core_hold;
                stop = 1;
            end else begin
                if (core_hold !== 1'b1 || inst_data !== 32'h0) hold_bad++;
                if (write_next && ld_byte_rdy !== 1'b0) rdy_bad++;
                write_next = 0;
                if (ld_done === 1'b1) begin
                    n_done++;
                    err_at_done = ld_err;
                    done_seen = 1;
                end
                acc = (ld_byte_rdy === 1'b1) && ld_byte_vld;
                @(posedge clk); #1;
                ld_start = (cyc == mid_cyc);
                cyc++;
                if (acc) begin
                    acc_word = {acc_word[23:0], bytes_q[idx]};
                    idx++;
                    n_acc++;
                    if (n_acc % 4 == 0) begin
                        exp_q.push_back('{word_idx, acc_word});
                        model_mem[word_idx] = acc_word;
                        sum_exp += acc_word;
                        word_idx++;
                        write_next = 1;
                    end
                    gap_left = gap;
                    if (stop_after > 0 && n_acc == stop_after) stop = 1;
                end else if (gap_left > 0) begin
                    gap_left--;
                end
                ld_byte_vld = (gap_left == 0) && (idx < bytes_q.size()) && !stop;
                ld_byte     = (idx < bytes_q.size()) ? bytes_q[idx] : 8'h00;
                if (cyc > 200) begin
                    timed_out = 1;
                    stop = 1;
                end
            end
        end
        ld_byte_vld = 1'b0;
        ld_start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ren = 1'b0; inst_addr = '0; ld_start = 1'b0;
        ld_len = '0; ld_byte_vld = 1'b0; ld_byte = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ld_busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", ld_busy); end
        checks++; if (core_hold !== 1'b0)   begin failures++; $display("FAIL reset_hold got=%b exp=0", core_hold); end
        checks++; if (ld_byte_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", ld_byte_rdy); end
        checks++; if (ld_done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", ld_done); end
        checks++; if (ld_err !== 1'b0)      begin failures++; $display("FAIL reset_err got=%b exp=0", ld_err); end
        checks++; if (ld_sum !== 32'h0)     begin failures++; $display("FAIL reset_sum got=%h exp=0", ld_sum); end
        checks++; if (inst_data !== 32'h0)  begin failures++; $display("FAIL reset_fetch got=%h exp=0", inst_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic fetch_scoreboard(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            inst_ren  = 1'b1;
            inst_addr = 32'(e.addr * 4);
            @(negedge clk);
            checks++;
            if (inst_data !== e.data) begin
                failures++;
                $display("FAIL %s_fetch_w%0d got=%h exp=%h", tag, e.addr, inst_data, e.data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_fetch();
        bytes_q = '{8'h34, 8'h08, 8'h00, 8'h01, 8'h3C, 8'h09, 8'h12, 8'h34};
        exp_q.delete();
        drive_load(2, 0, -1, 0);
        checks++; if (timed_out)      begin failures++; $display("FAIL lf_timeout got=1 exp=0"); end
        checks++; if (n_done != 1)    begin failures++; $display("FAIL lf_done_pulses got=%0d exp=1", n_done); end
        checks++; if (n_acc != 8)     begin failures++; $display("FAIL lf_bytes got=%0d exp=8", n_acc); end
        checks++; if (hold_bad != 0)  begin failures++; $display("FAIL lf_hold_nop bad_cycles=%0d exp=0", hold_bad); end
        checks++; if (hold_after !== 1'b0) begin failures++; $display("FAIL lf_hold_after got=%b exp=0", hold_after); end
        checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL lf_err got=%b exp=0", err_at_done); end
        checks++; if (ld_sum !== 32'h7011_1235) begin failures++; $display("FAIL lf_sum got=%h exp=70111235", ld_sum); end
        checks++; if (ld_sum !== sum_exp) begin failures++; $display("FAIL lf_sum_model got=%h exp=%h", ld_sum, sum_exp); end
        @(posedge clk); #1;
        fetch_scoreboard("lf");
    endtask

    task automatic test_spaced_load();
        bytes_q = '{8'h13, 8'h05, 8'h00, 8'h2A, 8'h77};
        exp_q.delete();
        drive_load(1, 3, 6, 0);
        checks++; if (timed_out)     begin failures++; $display("FAIL sp_timeout got=1 exp=0"); end
        checks++; if (n_acc != 4)    begin failures++; $display("FAIL sp_bytes got=%0d exp=4", n_acc); end
        checks++; if (rdy_bad != 0)  begin failures++; $display("FAIL sp_rdy_in_write bad=%0d exp=0", rdy_bad); end
        checks++; if (n_done != 1)   begin failures++; $display("FAIL sp_done_pulses got=%0d exp=1", n_done); end
        checks++; if (hold_bad != 0) begin failures++; $display("FAIL sp_hold_nop bad_cycles=%0d exp=0", hold_bad); end
        checks++; if (ld_sum !== 32'h1305_002A) begin failures++; $display("FAIL sp_sum got=%h exp=1305002a", ld_sum); end
        checks++; if (ld_byte_rdy !== 1'b0) begin failures++; $display("FAIL sp_rdy_idle got=%b exp=0", ld_byte_rdy); end
        @(posedge clk); #1;
        fetch_scoreboard("sp");
    endtask

    task automatic test_error();
        @(negedge clk);
        checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL er_pre got=%b exp=0", ld_err); end
        @(posedge clk); #1;
        bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_q.delete();
        drive_load((1 << DL) + 1, 0, -1, 0);
        checks++; if (n_acc != 0)    begin failures++; $display("FAIL er_bytes got=%0d exp=0", n_acc); end
        checks++; if (n_done != 1)   begin failures++; $display("FAIL er_done_pulses got=%0d exp=1", n_done); end
        checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL er_err_at_done got=%b exp=1", err_at_done); end
        checks++; if (hold_after !== 1'b0)  begin failures++; $display("FAIL er_hold_after got=%b exp=0", hold_after); end
        checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL er_err_holds got=%b exp=1", ld_err); end
        checks++; if (ld_sum !== 32'h0) begin failures++; $display("FAIL er_sum got=%h exp=0", ld_sum); end
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++) begin
            inst_ren = 1'b1; inst_addr = 32'(w * 4);
            @(negedge clk);
            checks++;
            if (inst_data !== model_mem[w]) begin
                failures++;
                $display("FAIL er_mem_w%0d got=%h exp=%h", w, inst_data, model_mem[w]);
            end
            @(posedge clk); #1;
        end
        bytes_q.delete();
        drive_load(0, 0, -1, 0);
        checks++; if (n_done != 1)   begin failures++; $display("FAIL er_len0_done got=%0d exp=1", n_done); end
        checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL er_clear got=%b exp=0", err_at_done); end
        checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL er_clear_hold got=%b exp=0", ld_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        bytes_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.delete();
        drive_load(2, 0, -1, 6);
        @(negedge clk);
        checks++; if (ld_busy !== 1'b1) begin failures++; $display("FAIL rm_busy_pre got=%b exp=1", ld_busy); end
        checks++; if (ld_sum !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rm_sum_pre got=%h exp=deadbeef", ld_sum); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ld_busy !== 1'b0)     begin failures++; $display("FAIL rm_busy got=%b exp=0", ld_busy); end
        checks++; if (core_hold !== 1'b0)   begin failures++; $display("FAIL rm_hold got=%b exp=0", core_hold); end
        checks++; if (ld_byte_rdy !== 1'b0) begin failures++; $display("FAIL rm_rdy got=%b exp=0", ld_byte_rdy); end
        checks++; if (ld_done !== 1'b0)     begin failures++; $display("FAIL rm_done got=%b exp=0", ld_done); end
        checks++; if (ld_err !== 1'b0)      begin failures++; $display("FAIL rm_err got=%b exp=0", ld_err); end
        checks++; if (ld_sum !== 32'h0)     begin failures++; $display("FAIL rm_sum got=%h exp=0", ld_sum); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fetch_scoreboard("rm");
    endtask

    task automatic test_fetch_rules();
        inst_ren = 1'b0; inst_addr = 32'h0;
        @(negedge clk);
        checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL fr_ren0 got=%h exp=0", inst_data); end
        @(posedge clk); #1;
        inst_ren = 1'b1; inst_addr = 32'h0000_1000;
        @(negedge clk);
        checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL fr_oor got=%h exp=0", inst_data); end
        @(posedge clk); #1;
        inst_addr = 32'h0000_0002;
        @(negedge clk);
        checks++; if (inst_data !== model_mem[0]) begin failures++; $display("FAIL fr_unaligned got=%h exp=%h", inst_data, model_mem[0]); end
        @(posedge clk); #1;
        inst_addr = 32'h0000_0007;
        @(negedge clk);
        checks++; if (inst_data !== model_mem[1]) begin failures++; $display("FAIL fr_word1 got=%h exp=%h", inst_data, model_mem[1]); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_spaced_load();
        test_error();
        test_reset_mid_load();
        test_fetch_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
